// File: rtl/up_counter_seq_pkg.sv
// Shared types and default widths for the up_counter_seq timer sequencer.
// The sequencer drives an external 8-bit loadable counter through parIn/ld/ci/cen/co.
package up_counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 8;
  localparam int DEF_WRAPS_W    = 8;

endpackage

// File: rtl/up_counter_seq_tick_prescaler.sv
// Prescaler for count strobes: counts 0..limit while en and pulses tick on limit.
// A tick or clr restarts the count at zero, so limit = all-ones never overflows.
module tick_prescaler
  import up_counter_seq_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = en & (cnt == limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/up_counter_seq.sv
// Programmable timer sequencer: loads the external counter, strobes it through a
// prescaler, detects carry-out wrap, then stops (one-shot) or reloads (periodic).
module up_counter_seq
  import up_counter_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int WRAPS_W    = DEF_WRAPS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  reload,
  input  logic [WIDTH-1:0]      loadVal,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      cnt_parIn,
  output logic                  cnt_ld,
  output logic                  cnt_ci,
  output logic                  cnt_cen,
  input  logic                  cnt_co,
  output logic                  busy,
  output logic                  done,
  output logic [WRAPS_W-1:0]    wrapCnt,
  output logic [1:0]            seq_state
);

  seq_state_t            state;
  logic [WIDTH-1:0]      load_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  reload_q;
  logic                  tick;
  logic                  wrap;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == LOAD),
    .en   (state == RUN),
    .limit(prescale_q),
    .tick (tick)
  );

  // Counter controls are decoded from the registered state so they align with it.
  assign cnt_parIn = load_q;
  assign cnt_cen   = (state == LOAD) || (state == RUN);
  assign cnt_ld    = (state == LOAD);
  assign cnt_ci    = (state == RUN) && tick;
  assign wrap      = cnt_ci & cnt_co;
  assign busy      = (state != IDLE);
  assign seq_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_q     <= '0;
      prescale_q <= '0;
      reload_q   <= 1'b0;
      done       <= 1'b0;
      wrapCnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            load_q     <= loadVal;
            prescale_q <= prescale;
            reload_q   <= reload;
            wrapCnt    <= '0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          state <= stop ? IDLE : RUN;
        end
        RUN: begin
          // An abort takes precedence over a coincident wrap and suppresses its bookkeeping.
          if (stop) begin
            state <= IDLE;
          end else if (wrap) begin
            done <= 1'b1;
            if (wrapCnt != '1) begin
              wrapCnt <= wrapCnt + 1'b1;
            end
            state <= reload_q ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_counter_seq.sv
// Self-checking bench for up_counter_seq with a behavioural model of the loadable counter.
// Per-cycle vector table for the one-shot cases, hand sequences for the multi-cycle corners.
module tb_up_counter_seq;
  import up_counter_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       reload;
  logic [7:0] loadVal;
  logic [7:0] prescale;
  logic [7:0] cnt_parIn;
  logic       cnt_ld;
  logic       cnt_ci;
  logic       cnt_cen;
  logic       cnt_co;
  logic       busy;
  logic       done;
  logic [7:0] wrapCnt;
  logic [1:0] seq_state;

  int checks;
  int errors;

  up_counter_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .reload   (reload),
    .loadVal  (loadVal),
    .prescale (prescale),
    .cnt_parIn(cnt_parIn),
    .cnt_ld   (cnt_ld),
    .cnt_ci   (cnt_ci),
    .cnt_cen  (cnt_cen),
    .cnt_co   (cnt_co),
    .busy     (busy),
    .done     (done),
    .wrapCnt  (wrapCnt),
    .seq_state(seq_state)
  );

  // clock / counter model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] cnt_q;
  initial cnt_q = 8'h00;
  assign cnt_co = cnt_ci & (cnt_q == 8'hFF);
  always @(posedge clk) begin
    if (cnt_cen) begin
      if (cnt_ld) cnt_q <= cnt_parIn;
      else if (cnt_ci) cnt_q <= cnt_q + 8'h01;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic idle_inputs;
    start = 1'b0;
    stop = 1'b0;
    reload = 1'b0;
  endtask

  typedef struct {
    logic       st;
    logic [7:0] lv;
    logic [7:0] p;
    logic       ld;
    logic       ci;
    logic       cen;
    logic       bsy;
    logic       dn;
    logic [7:0] par;
    logic [7:0] wc;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [7:0] lv, input logic [7:0] p,
                              input logic ld, input logic ci, input logic cen,
                              input logic bsy, input logic dn,
                              input logic [7:0] par, input logic [7:0] wc);
    vec_t v;
    v.st = st; v.lv = lv; v.p = p;
    v.ld = ld; v.ci = ci; v.cen = cen; v.bsy = bsy; v.dn = dn;
    v.par = par; v.wc = wc;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    int n;
    bit ok;
    int dones;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    loadVal = 8'h00;
    prescale = 8'h00;

    // one-shot FE/P=0 then one-shot FF/P=3, one row per cycle from the start cycle
    vecs[0]  = mk(1'b1, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    vecs[1]  = mk(1'b0, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFE, 8'h00);
    vecs[2]  = mk(1'b0, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFE, 8'h00);
    vecs[3]  = mk(1'b0, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFE, 8'h00);
    vecs[4]  = mk(1'b0, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 8'h01);
    vecs[5]  = mk(1'b0, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h01);
    vecs[6]  = mk(1'b1, 8'hFF, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h01);
    vecs[7]  = mk(1'b0, 8'hFF, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    vecs[8]  = mk(1'b0, 8'hFF, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    vecs[9]  = mk(1'b0, 8'hFF, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    vecs[10] = mk(1'b0, 8'hFF, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    vecs[11] = mk(1'b0, 8'hFF, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    vecs[12] = mk(1'b0, 8'hFF, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h01);
    vecs[13] = mk(1'b0, 8'hFF, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h01);

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_parIn", cnt_parIn, 0);
    check("rst_ld", cnt_ld, 0);
    check("rst_ci", cnt_ci, 0);
    check("rst_cen", cnt_cen, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrapCnt", wrapCnt, 0);
    check("rst_state", seq_state, IDLE);
    @(negedge clk);

    // tests 1 and 2: table-driven, outputs checked then inputs applied each cycle
    for (int i = 0; i < 14; i++) begin
      check($sformatf("v%0d_ld", i), cnt_ld, vecs[i].ld);
      check($sformatf("v%0d_ci", i), cnt_ci, vecs[i].ci);
      check($sformatf("v%0d_cen", i), cnt_cen, vecs[i].cen);
      check($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
      check($sformatf("v%0d_done", i), done, vecs[i].dn);
      check($sformatf("v%0d_parIn", i), cnt_parIn, vecs[i].par);
      check($sformatf("v%0d_wrapCnt", i), wrapCnt, vecs[i].wc);
      start = vecs[i].st;
      loadVal = vecs[i].lv;
      prescale = vecs[i].p;
      @(negedge clk);
    end
    idle_inputs();

    // test 3: periodic FD/P=0, done every 4 cycles, saturation, then stop
    start = 1'b1; reload = 1'b1; loadVal = 8'hFD; prescale = 8'h00;
    @(negedge clk);
    idle_inputs();
    for (int k = 1; k <= 300; k++) begin
      wait_done(20, n, ok);
      check($sformatf("per_done_seen%0d", k), ok, 1);
      check($sformatf("per_interval%0d", k), n, 4);
      check($sformatf("per_wrapCnt%0d", k), wrapCnt, (k > 255) ? 255 : k);
      check($sformatf("per_ld%0d", k), cnt_ld, 1);
      if (!ok) break;
    end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("per_stop_busy", busy, 0);
    check("per_stop_cen", cnt_cen, 0);
    check("per_stop_state", seq_state, IDLE);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("per_stop_no_done", dones, 0);
    check("per_stop_wrapCnt", wrapCnt, 255);

    // test 4: stop coincident with the second wrap
    start = 1'b1; reload = 1'b1; loadVal = 8'hFD; prescale = 8'h00;
    @(negedge clk);
    idle_inputs();
    wait_done(20, n, ok);
    check("sw_first_done", ok, 1);
    check("sw_first_wrapCnt", wrapCnt, 1);
    repeat (3) @(negedge clk);
    check("sw_ci_at_wrap", cnt_ci, 1);
    check("sw_co_at_wrap", cnt_co, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("sw_done", done, 0);
    check("sw_wrapCnt", wrapCnt, 1);
    check("sw_busy", busy, 0);
    check("sw_state", seq_state, IDLE);

    // test 5: start during RUN is ignored; timing keeps the original P=2
    @(negedge clk);
    start = 1'b1; reload = 1'b0; loadVal = 8'h10; prescale = 8'h02;
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    check("ign_state_run", seq_state, RUN);
    start = 1'b1; reload = 1'b1; loadVal = 8'h55; prescale = 8'h00;
    @(negedge clk);
    idle_inputs();
    check("ign_parIn", cnt_parIn, 8'h10);
    check("ign_busy", busy, 1);
    check("ign_wrapCnt", wrapCnt, 0);
    wait_done(1000, n, ok);
    check("ign_done_seen", ok, 1);
    check("ign_done_cycle", n, 716);
    check("ign_busy_at_done", busy, 0);
    check("ign_wrapCnt_done", wrapCnt, 1);
    @(negedge clk);
    check("ign_oneshot_idle", seq_state, IDLE);
    check("ign_parIn_after", cnt_parIn, 8'h10);

    // test 6: reset mid-RUN, then a fresh start
    start = 1'b1; reload = 1'b1; loadVal = 8'hFE; prescale = 8'h00;
    @(negedge clk);
    idle_inputs();
    repeat (7) @(negedge clk);
    check("mr_pre_wrapCnt", wrapCnt, 2);
    check("mr_pre_state", seq_state, RUN);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_parIn", cnt_parIn, 0);
    check("mr_ld", cnt_ld, 0);
    check("mr_ci", cnt_ci, 0);
    check("mr_cen", cnt_cen, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_wrapCnt", wrapCnt, 0);
    check("mr_state", seq_state, IDLE);
    start = 1'b1; reload = 1'b0; loadVal = 8'hFE; prescale = 8'h00;
    @(negedge clk);
    idle_inputs();
    check("mr_restart_ld", cnt_ld, 1);
    check("mr_restart_parIn", cnt_parIn, 8'hFE);
    wait_done(20, n, ok);
    check("mr_restart_done", ok, 1);
    check("mr_restart_cycle", n, 3);
    check("mr_restart_wrapCnt", wrapCnt, 1);
    check("mr_restart_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
